simpleio_buf: RTL and testbench

- Parametrised successor to the single-byte memory-mapped I/O block on the 8-bit CPU bus.
- Provides LED, RGB, hex, switch and key I/O plus a UART with RX and TX FIFOs of configurable depth.
- Adds a maskable interrupt line and sticky error flags.
- Instantiates the existing `uart` core (AXI-stream byte interface, 16-bit prescale).

---
 rtl/simpleio_buf.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_simpleio_buf.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/simpleio_buf.sv
// simpleio_buf: byte-wide memory-mapped LED/RGB/hex/switch/key I/O with a FIFO-buffered UART and interrupts.
// Optional macro SIMPLEIO_BUF_LOOPBACK_EN adds register 0x7 (bit0 = internal UART loopback).

module uart (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  input_axis_tdata,
    input  logic        input_axis_tvalid,
    output logic        input_axis_tready,
    output logic [7:0]  output_axis_tdata,
    output logic        output_axis_tvalid,
    input  logic        output_axis_tready,
    input  logic        rxd,
    output logic        txd,
    output logic        tx_busy,
    output logic        rx_busy,
    output logic        rx_overrun_error,
    output logic        rx_frame_error,
    input  logic [15:0] prescale
);
    // One bit lasts prescale*8 clocks; the receiver samples mid-bit.
    logic [18:0] bit_len;
    logic [18:0] half_len;
    assign bit_len  = {prescale, 3'b000} - 19'd1;
    assign half_len = {1'b0, prescale, 2'b00} - 19'd1;

    logic [18:0] tx_tmr;
    logic [3:0]  tx_bits;
    logic [8:0]  tx_sh;

    assign input_axis_tready = !tx_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_tmr  <= '0;
            tx_bits <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (input_axis_tvalid) begin
                txd     <= 1'b0;
                tx_busy <= 1'b1;
                tx_sh   <= {1'b1, input_axis_tdata};
                tx_bits <= 4'd9;
                tx_tmr  <= bit_len;
            end
        end else if (tx_tmr != '0) begin
            tx_tmr <= tx_tmr - 19'd1;
        end else if (tx_bits != '0) begin
            txd     <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[8:1]};
            tx_bits <= tx_bits - 4'd1;
            tx_tmr  <= bit_len;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    logic [1:0]  rxd_sync;
    logic [18:0] rx_tmr;
    logic [3:0]  rx_bits;
    logic [7:0]  rx_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_sync           <= 2'b11;
            rx_busy            <= 1'b0;
            rx_tmr             <= '0;
            rx_bits            <= '0;
            rx_sh              <= '0;
            output_axis_tdata  <= '0;
            output_axis_tvalid <= 1'b0;
            rx_overrun_error   <= 1'b0;
            rx_frame_error     <= 1'b0;
        end else begin
            rxd_sync         <= {rxd_sync[0], rxd};
            rx_overrun_error <= 1'b0;
            rx_frame_error   <= 1'b0;
            if (output_axis_tvalid && output_axis_tready)
                output_axis_tvalid <= 1'b0;
            if (!rx_busy) begin
                if (!rxd_sync[1]) begin
                    rx_busy <= 1'b1;
                    rx_bits <= 4'd10;
                    rx_tmr  <= half_len;
                end
            end else if (rx_tmr != '0) begin
                rx_tmr <= rx_tmr - 19'd1;
            end else begin
                rx_tmr <= bit_len;
                if (rx_bits == 4'd10) begin
                    if (rxd_sync[1])
                        rx_busy <= 1'b0;
                    else
                        rx_bits <= 4'd9;
                end else if (rx_bits != 4'd1) begin
                    rx_sh   <= {rxd_sync[1], rx_sh[7:1]};
                    rx_bits <= rx_bits - 4'd1;
                end else begin
                    // Stop bit: a byte still waiting in the output register means overrun.
                    rx_busy <= 1'b0;
                    if (!rxd_sync[1]) begin
                        rx_frame_error <= 1'b1;
                    end else if (output_axis_tvalid && !output_axis_tready) begin
                        rx_overrun_error <= 1'b1;
                    end else begin
                        output_axis_tdata  <= rx_sh;
                        output_axis_tvalid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

module simpleio_buf_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    logic [7:0]  mem [2**AW];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module simpleio_buf #(
    parameter int          LED_WIDTH     = 8,
    parameter int          FIFO_AW       = 4,
    parameter logic [15:0] PRESCALE_INIT = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           Address,
    input  logic [7:0]           DI,
    output logic [7:0]           DO,
    input  logic                 rw,
    input  logic                 cs,
    output logic                 irq,
    output logic [LED_WIDTH-1:0] leds,
    output logic [7:0]           hex_disp,
    output logic [2:0]           rgb1,
    output logic [2:0]           rgb2,
    input  logic [3:0]           switches,
    input  logic [3:0]           keys,
    input  logic                 rxd,
    output logic                 txd
);
    localparam logic [15:0] LED_MASK = 16'((32'h1 << LED_WIDTH) - 32'h1);

    logic        wr, rd;
    logic [15:0] leds_r;
    logic [15:0] prescale;
    logic [4:0]  ie;
    logic [4:2]  is_sticky;
    logic [4:2]  is_set;
    logic [4:0]  is_val;
    logic [7:0]  io_meta, io_sync;
    logic [3:0]  key_prev;
    logic [7:0]  rd_data;
    logic [7:0]  lb_rd;

    logic              tx_full, tx_empty, tx_pop, tx_push, tx_drop;
    logic              rx_full, rx_empty, rx_pop;
    logic [7:0]        tx_head, rx_head;
    logic [FIFO_AW:0]  tx_count, rx_count;
    logic              u_tx_tready, u_rx_tvalid;
    logic [7:0]        u_rx_tdata;
    logic              u_rxd, u_txd, u_tx_busy, u_rx_busy, u_ovr, u_frm;

    assign wr      = cs && !rw;
    assign rd      = cs && rw;
    assign tx_push = wr && (Address == 4'h8);
    assign rx_pop  = rd && (Address == 4'h8);
    assign tx_pop  = !tx_empty && u_tx_tready;
    assign tx_drop = tx_push && tx_full && !tx_pop;

    assign is_set = {|(io_sync[3:0] & ~key_prev), tx_drop, u_ovr | u_frm};
    assign is_val = {is_sticky, tx_empty, !rx_empty};
    assign leds   = leds_r[LED_WIDTH-1:0];

    simpleio_buf_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(DI),
        .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    simpleio_buf_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(u_rx_tvalid && !rx_full), .pop(rx_pop), .din(u_rx_tdata),
        .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart u_uart (
        .clk(clk), .rst(rst),
        .input_axis_tdata(tx_head), .input_axis_tvalid(!tx_empty), .input_axis_tready(u_tx_tready),
        .output_axis_tdata(u_rx_tdata), .output_axis_tvalid(u_rx_tvalid), .output_axis_tready(!rx_full),
        .rxd(u_rxd), .txd(u_txd), .tx_busy(u_tx_busy), .rx_busy(u_rx_busy),
        .rx_overrun_error(u_ovr), .rx_frame_error(u_frm), .prescale(prescale)
    );

`ifdef SIMPLEIO_BUF_LOOPBACK_EN
    logic lb;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lb <= 1'b0;
        else if (wr && (Address == 4'h7))
            lb <= DI[0];
    end
    assign u_rxd = lb ? u_txd : rxd;
    assign txd   = lb ? 1'b1 : u_txd;
    assign lb_rd = {7'b0, lb};
`else
    assign u_rxd = rxd;
    assign txd   = u_txd;
    assign lb_rd = 8'h00;
`endif

    function automatic logic [7:0] sat8(input logic [FIFO_AW:0] c);
        return (32'(c) > 32'd255) ? 8'hFF : 8'(c);
    endfunction

    always_comb begin
        rd_data = 8'h00;
        case (Address)
            4'h0: rd_data = leds_r[7:0] & LED_MASK[7:0];
            4'h1: rd_data = leds_r[15:8] & LED_MASK[15:8];
            4'h2: rd_data = hex_disp;
            4'h3: rd_data = {1'b0, rgb1, 1'b0, rgb2};
            4'h4: rd_data = io_sync;
            4'h5: rd_data = {3'b0, ie};
            4'h6: rd_data = {3'b0, is_val};
            4'h7: rd_data = lb_rd;
            4'h8: rd_data = rx_empty ? 8'h00 : rx_head;
            4'h9: rd_data = {u_rx_busy, u_tx_busy, is_sticky[2], is_sticky[3],
                             tx_full, tx_empty, rx_full, !rx_empty};
            4'hA: rd_data = prescale[15:8];
            4'hB: rd_data = prescale[7:0];
            4'hC: rd_data = sat8(rx_count);
            4'hD: rd_data = sat8(tx_count);
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_r    <= 16'hFFFF;
            hex_disp  <= 8'h00;
            rgb1      <= 3'b111;
            rgb2      <= 3'b111;
            prescale  <= PRESCALE_INIT;
            ie        <= '0;
            is_sticky <= '0;
            io_meta   <= '0;
            io_sync   <= '0;
            key_prev  <= '0;
            DO        <= 8'h00;
            irq       <= 1'b0;
        end else begin
            io_meta  <= {switches, keys};
            io_sync  <= io_meta;
            key_prev <= io_sync[3:0];
            irq      <= |(is_val & ie);
            // New events override a W1C of the same bit in the same cycle.
            is_sticky <= (is_sticky & ~((wr && (Address == 4'h6)) ? DI[4:2] : 3'b000)) | is_set;
            if (rd) DO <= rd_data;
            if (wr) begin
                case (Address)
                    4'h0: leds_r[7:0]    <= DI;
                    4'h1: leds_r[15:8]   <= DI;
                    4'h2: hex_disp       <= DI;
                    4'h3: begin
                        rgb1 <= DI[6:4];
                        rgb2 <= DI[2:0];
                    end
                    4'h5: ie             <= DI[4:0];
                    4'hA: prescale[15:8] <= DI;
                    4'hB: prescale[7:0]  <= DI;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_simpleio_buf.sv
// Scoreboard bench for simpleio_buf: bus reads and serial TX frames are checked by monitors against queued expectations.
module tb_simpleio_buf;
    localparam logic [15:0] PINIT = 16'h0123;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] Address = 4'h0;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       rw = 1'b0;
    logic       cs = 1'b0;
    logic       irq;
    logic [7:0] leds;
    logic [7:0] hex_disp;
    logic [2:0] rgb1, rgb2;
    logic [3:0] switches = 4'h0;
    logic [3:0] keys = 4'h0;
    logic       rxd = 1'b1;
    logic       txd;

    int total = 0;
    int bad = 0;

    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_mask_q[$];
    string      rd_name_q[$];
    logic [7:0] tx_q[$];
    logic       rd_flag = 1'b0;

    always #5 clk = ~clk;

    simpleio_buf #(.LED_WIDTH(8), .FIFO_AW(2), .PRESCALE_INIT(PINIT)) dut (
        .clk(clk), .rst(rst), .Address(Address), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .irq(irq), .leds(leds), .hex_disp(hex_disp), .rgb1(rgb1), .rgb2(rgb2),
        .switches(switches), .keys(keys), .rxd(rxd), .txd(txd)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [3:0] a, input logic [7:0] d, input logic r);
        @(negedge clk);
        Address = a; DI = d; rw = r; cs = 1'b1;
        @(negedge clk);
        cs = 1'b0; rw = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus(a, d, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e, input string n);
        rd_exp_q.push_back(e); rd_mask_q.push_back(8'hFF); rd_name_q.push_back(n);
        bus(a, 8'h00, 1'b1);
    endtask

    task automatic rd_any(input logic [3:0] a);
        rd_exp_q.push_back(8'h00); rd_mask_q.push_back(8'h00); rd_name_q.push_back("any");
        bus(a, 8'h00, 1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        rxd = 1'b0; repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i]; repeat (8) @(negedge clk);
        end
        rxd = 1'b1; repeat (8) @(negedge clk);
    endtask

    // Read monitor: DO is valid at the falling edge after a cs&&rw rising edge.
    always @(posedge clk) rd_flag <= cs && rw;

    always @(negedge clk) begin
        if (rd_flag) begin
            if (rd_exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %h want none", DO);
            end else begin
                logic [7:0] e, m;
                string n;
                e = rd_exp_q.pop_front(); m = rd_mask_q.pop_front(); n = rd_name_q.pop_front();
                if (m != 8'h00) chk(n, DO & m, e & m);
            end
        end
    end

    // TX monitor: decode 8N1 frames at 8 clocks per bit, sampling mid-bit.
    initial begin
        logic [7:0] b, e;
        logic       stp;
        forever begin
            @(negedge clk);
            if (rst && txd === 1'b0) begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    b[i] = txd;
                end
                repeat (8) @(negedge clk);
                stp = txd;
                total++;
                if (tx_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_frame: got unexpected byte %h want none", b);
                end else begin
                    e = tx_q.pop_front();
                    if (b !== e || stp !== 1'b1) begin
                        bad++;
                        $display("FAIL tx_frame: got %h stop %b want %h stop 1", b, stp, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen0;
        switches = 4'hA;
        repeat (3) @(negedge clk);
        chk("rst_leds", leds, 8'hFF);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_hex", hex_disp, 8'h00);
        chk("rst_txd", {7'b0, txd}, 8'h01);
        chk("rst_do", DO, 8'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rd(4'h3, 8'h77, "rst_rgb");
        rd(4'h9, 8'h04, "rst_stat");
        rd(4'hA, 8'h01, "rst_pre_hi");
        rd(4'hB, 8'h23, "rst_pre_lo");
        rd(4'h6, 8'h02, "rst_is");
        rd(4'h4, 8'hA0, "sw_keys");

        wr(4'h0, 8'h3C); chk("leds_w", leds, 8'h3C); rd(4'h0, 8'h3C, "leds_r");
        wr(4'h1, 8'hFF); rd(4'h1, 8'h00, "leds_hi");
        wr(4'h2, 8'h9E); chk("hex_w", hex_disp, 8'h9E); rd(4'h2, 8'h9E, "hex_r");
        wr(4'h3, 8'hFF); rd(4'h3, 8'h77, "rgb_mask");
        wr(4'h3, 8'h25); chk("rgb1", {5'b0, rgb1}, 8'h02); chk("rgb2", {5'b0, rgb2}, 8'h05);
        rd(4'h3, 8'h25, "rgb_r");
        wr(4'hF, 8'h55); rd(4'hF, 8'h00, "undec_f"); rd(4'hE, 8'h00, "undec_e");
`ifndef SIMPLEIO_BUF_LOOPBACK_EN
        wr(4'h7, 8'h01); rd(4'h7, 8'h00, "reg7_absent");
`endif
        wr(4'h5, 8'hFF); rd(4'h5, 8'h1F, "ie_r");
        wr(4'h5, 8'h02);
        wr(4'h5, 8'h00); chk("irq_lag", {7'b0, irq}, 8'h01);
        repeat (2) @(negedge clk); chk("irq_off", {7'b0, irq}, 8'h00);

        wr(4'hA, 8'h00); wr(4'hB, 8'h01);
        rd(4'hA, 8'h00, "pre_hi"); rd(4'hB, 8'h01, "pre_lo");

        tx_q.push_back(8'h55); tx_q.push_back(8'hA3);
        wr(4'h8, 8'h55); wr(4'h8, 8'hA3);
        rd(4'hD, 8'h01, "txcnt_busy"); rd(4'h6, 8'h00, "is_txbusy");
        repeat (200) @(negedge clk);
        chk("tx_pair_sent", 8'(tx_q.size()), 8'h00);
        rd(4'hD, 8'h00, "txcnt_done"); rd(4'h6, 8'h02, "is_txempty");

        tx_q.push_back(8'h11); wr(4'h8, 8'h11);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) tx_q.push_back(8'(8'h21 + i));
            wr(4'h8, 8'(8'h21 + i));
        end
        rd(4'hD, 8'h04, "txcnt_full"); rd(4'h6, 8'h08, "is_txovf"); rd(4'h9, 8'h58, "stat_txfull");
        wr(4'h6, 8'h08); rd(4'h6, 8'h00, "is_w1c_ovf");
        repeat (450) @(negedge clk);
        chk("tx_ovf_sent", 8'(tx_q.size()), 8'h00);
        rd(4'h9, 8'h04, "stat_txidle");

        send(8'h31); send(8'h32);
        repeat (10) @(negedge clk);
        rd(4'hC, 8'h02, "rxcnt2"); rd(4'h6, 8'h03, "is_rx");
        rd(4'h8, 8'h31, "rx0"); rd(4'h8, 8'h32, "rx1"); rd(4'h8, 8'h00, "rx_empty_pop");
        rd(4'hC, 8'h00, "rxcnt0");

        for (int i = 0; i < 6; i++) send(8'(8'h41 + i));
        repeat (10) @(negedge clk);
        rd(4'h9, 8'h27, "stat_rxfull");
        wr(4'h5, 8'h04);
        repeat (2) @(negedge clk); chk("irq_rxerr", {7'b0, irq}, 8'h01);
        for (int i = 0; i < 4; i++) rd(4'h8, 8'(8'h41 + i), "rxfull_pop");
        chk("irq_rxerr_hold", {7'b0, irq}, 8'h01);
        wr(4'h6, 8'h04);
        repeat (2) @(negedge clk); chk("irq_rxerr_clr", {7'b0, irq}, 8'h00);
        rd_any(4'h8); rd_any(4'h8);
        rd(4'hC, 8'h00, "rx_drained");

        wr(4'h5, 8'h10);
        keys = 4'h1; repeat (4) @(negedge clk);
        keys = 4'h0; repeat (4) @(negedge clk);
        chk("irq_key", {7'b0, irq}, 8'h01);
        rd(4'h6, 8'h12, "is_key");
        wr(4'h6, 8'h10);
        repeat (2) @(negedge clk); chk("irq_key_clr", {7'b0, irq}, 8'h00);
        rd(4'h6, 8'h02, "is_key_clr");
        wr(4'h5, 8'h00);

`ifdef SIMPLEIO_BUF_LOOPBACK_EN
        wr(4'h7, 8'hFF); rd(4'h7, 8'h01, "lb_reg");
        wr(4'h8, 8'hC6);
        seen0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) seen0 = 1'b1;
        end
        chk("lb_txd_idle", {7'b0, seen0}, 8'h00);
        repeat (10) @(negedge clk);
        rd(4'hC, 8'h01, "lb_rxcnt"); rd(4'h8, 8'hC6, "lb_rxdata");
        wr(4'h7, 8'h00);
`else
        seen0 = 1'b0;
        chk("lb_absent_flag", {7'b0, seen0}, {7'b0, txd ^ 1'b1});
`endif

        repeat (3) @(negedge clk);
        chk("rd_q_empty", 8'(rd_exp_q.size()), 8'h00);
        chk("tx_q_empty", 8'(tx_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
